// File: rtl/cnn_pkg.sv
// Shared types for the 2x2 convolution sequencer: FSM states and window slot indices.
package cnn_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_F0,
    S_F1,
    S_F2,
    S_F3,
    S_WAIT,
    S_WRITE,
    S_DONE
  } state_t;

  localparam int unsigned SLOT_A0 = 0;
  localparam int unsigned SLOT_A1 = 1;
  localparam int unsigned SLOT_A2 = 2;
  localparam int unsigned SLOT_A3 = 3;
  localparam int unsigned NSLOT   = 4;

endpackage

// File: rtl/conv_addr_gen.sv
// Window position tracking for conv2x2_sched: row/column counters, running row base
// and output pointer, producing the four read addresses, the write address and a last-window flag.
module conv_addr_gen
  import cnn_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_clear,
  input  logic                          i_step,
  input  logic [ADDR_W-1:0]             i_img_w,
  input  logic [ADDR_W-1:0]             i_img_h,
  input  logic [ADDR_W-1:0]             i_in_base,
  input  logic [ADDR_W-1:0]             i_out_base,
  output logic [NSLOT-1:0][ADDR_W-1:0]  o_rd_addr,
  output logic [ADDR_W-1:0]             o_wr_addr,
  output logic                          o_last
);

  logic [ADDR_W-1:0] r_r;
  logic [ADDR_W-1:0] r_c;
  logic [ADDR_W-1:0] r_row_base;
  logic [ADDR_W-1:0] r_out_addr;

  logic [ADDR_W-1:0] w_base;
  logic [ADDR_W-1:0] w_wm2;
  logic [ADDR_W-1:0] w_hm2;
  logic              w_row_end;

  assign w_wm2     = i_img_w - ADDR_W'(2);
  assign w_hm2     = i_img_h - ADDR_W'(2);
  // Column img_w-2 is the last window start in a row; likewise for rows.
  assign w_row_end = (r_c == w_wm2);
  assign o_last    = w_row_end && (r_r == w_hm2);

  assign w_base              = i_in_base + r_row_base + r_c;
  assign o_rd_addr[SLOT_A0]  = w_base;
  assign o_rd_addr[SLOT_A1]  = w_base + ADDR_W'(1);
  assign o_rd_addr[SLOT_A2]  = w_base + i_img_w;
  assign o_rd_addr[SLOT_A3]  = w_base + i_img_w + ADDR_W'(1);
  assign o_wr_addr           = r_out_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_r        <= '0;
      r_c        <= '0;
      r_row_base <= '0;
      r_out_addr <= '0;
    end else if (i_clear) begin
      r_r        <= '0;
      r_c        <= '0;
      r_row_base <= '0;
      r_out_addr <= i_out_base;
    end else if (i_step) begin
      r_out_addr <= r_out_addr + ADDR_W'(1);
      if (w_row_end) begin
        r_c        <= '0;
        r_r        <= r_r + ADDR_W'(1);
        r_row_base <= r_row_base + i_img_w;
      end else begin
        r_c        <= r_c + ADDR_W'(1);
      end
    end
  end

endmodule

// File: rtl/conv2x2_sched.sv
// Sequencer for a stride-1 valid 2x2 convolution: fetches each window through one SRAM
// read port, presents window and kernel to the external MAC, and writes the result back.
module conv2x2_sched
  import cnn_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned ADDR_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     img_w,
  input  logic [ADDR_W-1:0]     img_h,
  input  logic [ADDR_W-1:0]     in_base,
  input  logic [ADDR_W-1:0]     out_base,
  input  logic [4*WIDTH-1:0]    kernel,
  output logic                  busy,
  output logic                  done,
  output logic                  rd_en,
  output logic [ADDR_W-1:0]     rd_addr,
  input  logic [WIDTH-1:0]      rd_data,
  output logic [4*WIDTH-1:0]    mac_a,
  output logic [4*WIDTH-1:0]    mac_k,
  input  logic [WIDTH-1:0]      mac_out,
  output logic                  wr_en,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic [WIDTH-1:0]      wr_data
);

  state_t r_state;
  state_t w_next;

  logic [ADDR_W-1:0]  r_img_w;
  logic [ADDR_W-1:0]  r_img_h;
  logic [ADDR_W-1:0]  r_in_base;
  logic [4*WIDTH-1:0] r_kernel;
  logic [4*WIDTH-1:0] r_win;

  logic                         w_accept;
  logic                         w_step;
  logic                         w_last;
  logic [NSLOT-1:0][ADDR_W-1:0] w_rd_addr;
  logic [ADDR_W-1:0]            w_wr_addr;

  assign w_accept = (r_state == S_IDLE) && start;
  assign w_step   = (r_state == S_WRITE);

  conv_addr_gen #(
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk        (clk),
    .rst        (rst),
    .i_clear    (w_accept),
    .i_step     (w_step),
    .i_img_w    (r_img_w),
    .i_img_h    (r_img_h),
    .i_in_base  (r_in_base),
    .i_out_base (out_base),
    .o_rd_addr  (w_rd_addr),
    .o_wr_addr  (w_wr_addr),
    .o_last     (w_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Read data lags the strobe by one cycle, so each state captures the previous slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_img_w   <= '0;
      r_img_h   <= '0;
      r_in_base <= '0;
      r_kernel  <= '0;
      r_win     <= '0;
    end else begin
      if (w_accept) begin
        r_img_w   <= img_w;
        r_img_h   <= img_h;
        r_in_base <= in_base;
        r_kernel  <= kernel;
      end
      case (r_state)
        S_F1:    r_win[SLOT_A0*WIDTH +: WIDTH] <= rd_data;
        S_F2:    r_win[SLOT_A1*WIDTH +: WIDTH] <= rd_data;
        S_F3:    r_win[SLOT_A2*WIDTH +: WIDTH] <= rd_data;
        S_WAIT:  r_win[SLOT_A3*WIDTH +: WIDTH] <= rd_data;
        default: ;
      endcase
    end
  end

  assign mac_a = r_win;
  assign mac_k = r_kernel;

  always_comb begin
    w_next  = r_state;
    busy    = 1'b0;
    done    = 1'b0;
    rd_en   = 1'b0;
    rd_addr = '0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if ((img_w < ADDR_W'(2)) || (img_h < ADDR_W'(2))) begin
            w_next = S_DONE;
          end else begin
            w_next = S_F0;
          end
        end
      end
      S_F0: begin
        busy    = 1'b1;
        rd_en   = 1'b1;
        rd_addr = w_rd_addr[SLOT_A0];
        w_next  = S_F1;
      end
      S_F1: begin
        busy    = 1'b1;
        rd_en   = 1'b1;
        rd_addr = w_rd_addr[SLOT_A1];
        w_next  = S_F2;
      end
      S_F2: begin
        busy    = 1'b1;
        rd_en   = 1'b1;
        rd_addr = w_rd_addr[SLOT_A2];
        w_next  = S_F3;
      end
      S_F3: begin
        busy    = 1'b1;
        rd_en   = 1'b1;
        rd_addr = w_rd_addr[SLOT_A3];
        w_next  = S_WAIT;
      end
      S_WAIT: begin
        busy   = 1'b1;
        w_next = S_WRITE;
      end
      S_WRITE: begin
        busy    = 1'b1;
        wr_en   = 1'b1;
        wr_addr = w_wr_addr;
        wr_data = mac_out;
        w_next  = w_last ? S_DONE : S_F0;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_conv2x2_sched.sv
// Directed bench for conv2x2_sched with a behavioural SRAM and MAC around the DUT.
module tb_conv2x2_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  img_w = '0;
  logic [7:0]  img_h = '0;
  logic [7:0]  in_base = '0;
  logic [7:0]  out_base = '0;
  logic [31:0] kernel = '0;
  logic        busy, done, rd_en, wr_en;
  logic [7:0]  rd_addr, wr_addr, wr_data, mac_out;
  logic [7:0]  rd_data = '0;
  logic [31:0] mac_a, mac_k;
  logic [31:0] acc;

  logic [7:0]  mem [256];

  int checks = 0;
  int failures = 0;

  int done_cyc, ndone, nbusy, busy_first, busy_last, overlap;
  logic [7:0] rd_q[$];
  logic [7:0] wa_q[$];
  logic [7:0] wd_q[$];

  conv2x2_sched #(.WIDTH(8), .ADDR_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .img_w    (img_w),
    .img_h    (img_h),
    .in_base  (in_base),
    .out_base (out_base),
    .kernel   (kernel),
    .busy     (busy),
    .done     (done),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .mac_a    (mac_a),
    .mac_k    (mac_k),
    .mac_out  (mac_out),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rd_data <= rd_en ? mem[rd_addr] : 8'h00;

  always_comb begin
    acc = '0;
    for (int k = 0; k < 4; k++)
      acc = acc + 32'(mac_a[k*8 +: 8]) * 32'(mac_k[k*8 +: 8]);
    mac_out = acc[7:0];
  end

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  endtask

  task automatic set_cfg(input logic [7:0] w, input logic [7:0] h, input logic [7:0] ib,
                         input logic [7:0] ob, input logic [31:0] k);
    img_w = w; img_h = h; in_base = ib; out_base = ob; kernel = k;
  endtask

  // Pulses start (accepted at edge 0) and logs activity per cycle, cycle 1 being the first after it.
  task automatic run_job(input int max_cyc, input int inj_busy, input bit inj_done, input int abort_cyc);
    done_cyc = -1; ndone = 0; nbusy = 0; busy_first = -1; busy_last = -1; overlap = 0;
    rd_q.delete(); wa_q.delete(); wd_q.delete();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    img_w = 8'hA5; img_h = 8'h5A; in_base = 8'h33; out_base = 8'hCC; kernel = 32'hDEADBEEF;
    for (int cyc = 1; cyc <= max_cyc; cyc++) begin
      @(negedge clk);
      if (busy) begin
        nbusy++;
        if (busy_first < 0) busy_first = cyc;
        busy_last = cyc;
      end
      if (rd_en) rd_q.push_back(rd_addr);
      if (wr_en) begin wa_q.push_back(wr_addr); wd_q.push_back(wr_data); end
      if (rd_en && wr_en) overlap++;
      if (done) begin
        ndone++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (cyc == inj_busy) start = 1'b1;
      else if (inj_done && done) start = 1'b1;
      else start = 1'b0;
      if (cyc == abort_cyc) begin
        start = 1'b0;
        rst = 1'b1;
        return;
      end
      if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (rd_en !== 1'b0 || wr_en !== 1'b0) begin failures++; $display("FAIL reset_strobes got=%b%b exp=00", rd_en, wr_en); end
    checks++; if (rd_addr !== 8'h00 || wr_addr !== 8'h00 || wr_data !== 8'h00) begin failures++;
      $display("FAIL reset_addr_data got=%h/%h/%h exp=00/00/00", rd_addr, wr_addr, wr_data); end
    checks++; if (mac_a !== 32'h0 || mac_k !== 32'h0) begin failures++; $display("FAIL reset_mac got=%h/%h exp=0/0", mac_a, mac_k); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_ones_3x3();
    clear_mem();
    for (int i = 0; i < 9; i++) mem[i] = 8'h01;
    set_cfg(8'd3, 8'd3, 8'h00, 8'h40, 32'h01010101);
    run_job(60, 0, 1'b0, 0);
    checks++; if (done_cyc !== 25) begin failures++; $display("FAIL ones_done_cycle got=%0d exp=25", done_cyc); end
    checks++; if (ndone !== 1) begin failures++; $display("FAIL ones_done_count got=%0d exp=1", ndone); end
    checks++; if (busy_first !== 1 || busy_last !== 24 || nbusy !== 24) begin failures++;
      $display("FAIL ones_busy_window got=%0d..%0d n=%0d exp=1..24 n=24", busy_first, busy_last, nbusy); end
    checks++; if (rd_q.size() !== 16) begin failures++; $display("FAIL ones_read_count got=%0d exp=16", rd_q.size()); end
    checks++; if (overlap !== 0) begin failures++; $display("FAIL ones_rd_wr_overlap got=%0d exp=0", overlap); end
    checks++; if (wa_q.size() !== 4) begin failures++; $display("FAIL ones_write_count got=%0d exp=4", wa_q.size()); end
    for (int i = 0; i < wa_q.size(); i++) begin
      checks++;
      if (wa_q[i] !== 8'(8'h40 + i) || wd_q[i] !== 8'h04) begin failures++;
        $display("FAIL ones_write%0d got=%h:%h exp=%h:04", i, wa_q[i], wd_q[i], 8'(8'h40 + i)); end
    end
  endtask

  task automatic test_3x2_ramp();
    logic [7:0] exp_rd [8] = '{8'd0, 8'd1, 8'd3, 8'd4, 8'd1, 8'd2, 8'd4, 8'd5};
    logic [7:0] exp_wd [2] = '{8'd37, 8'd47};
    clear_mem();
    for (int i = 0; i < 6; i++) mem[i] = 8'(i + 1);
    set_cfg(8'd3, 8'd2, 8'h00, 8'h80, {8'd4, 8'd3, 8'd2, 8'd1});
    run_job(60, 0, 1'b0, 0);
    checks++; if (done_cyc !== 13) begin failures++; $display("FAIL ramp_done_cycle got=%0d exp=13", done_cyc); end
    checks++; if (rd_q.size() !== 8) begin failures++; $display("FAIL ramp_read_count got=%0d exp=8", rd_q.size()); end
    for (int i = 0; i < rd_q.size(); i++) begin
      checks++;
      if (rd_q[i] !== exp_rd[i]) begin failures++; $display("FAIL ramp_read%0d got=%h exp=%h", i, rd_q[i], exp_rd[i]); end
    end
    checks++; if (wa_q.size() !== 2) begin failures++; $display("FAIL ramp_write_count got=%0d exp=2", wa_q.size()); end
    for (int i = 0; i < wa_q.size(); i++) begin
      checks++;
      if (wa_q[i] !== 8'(8'h80 + i) || wd_q[i] !== exp_wd[i]) begin failures++;
        $display("FAIL ramp_write%0d got=%h:%0d exp=%h:%0d", i, wa_q[i], wd_q[i], 8'(8'h80 + i), exp_wd[i]); end
    end
  endtask

  task automatic test_degenerate();
    set_cfg(8'd1, 8'd5, 8'h00, 8'h20, 32'h01010101);
    run_job(20, 0, 1'b0, 0);
    checks++; if (done_cyc !== 1) begin failures++; $display("FAIL degen_done_cycle got=%0d exp=1", done_cyc); end
    checks++; if (rd_q.size() !== 0 || wa_q.size() !== 0) begin failures++;
      $display("FAIL degen_no_access got=rd%0d/wr%0d exp=rd0/wr0", rd_q.size(), wa_q.size()); end
    checks++; if (nbusy !== 0) begin failures++; $display("FAIL degen_busy got=%0d exp=0", nbusy); end
  endtask

  task automatic test_wrap();
    logic [7:0] exp_rd [4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    clear_mem();
    mem[8'hFE] = 8'hFF; mem[8'hFF] = 8'hFF; mem[8'h00] = 8'hFF; mem[8'h01] = 8'hFF;
    set_cfg(8'd2, 8'd2, 8'hFE, 8'h10, 32'hFFFFFFFF);
    run_job(30, 0, 1'b0, 0);
    checks++; if (done_cyc !== 7) begin failures++; $display("FAIL wrap_done_cycle got=%0d exp=7", done_cyc); end
    checks++; if (rd_q.size() !== 4) begin failures++; $display("FAIL wrap_read_count got=%0d exp=4", rd_q.size()); end
    for (int i = 0; i < rd_q.size(); i++) begin
      checks++;
      if (rd_q[i] !== exp_rd[i]) begin failures++; $display("FAIL wrap_read%0d got=%h exp=%h", i, rd_q[i], exp_rd[i]); end
    end
    checks++; if (wa_q.size() !== 1) begin failures++; $display("FAIL wrap_write_count got=%0d exp=1", wa_q.size()); end
    else begin
      checks++; if (wa_q[0] !== 8'h10 || wd_q[0] !== 8'h04) begin failures++;
        $display("FAIL wrap_write got=%h:%h exp=10:04", wa_q[0], wd_q[0]); end
    end
  endtask

  task automatic test_reset_midjob();
    int late_done;
    clear_mem();
    for (int i = 0; i < 9; i++) mem[i] = 8'h01;
    set_cfg(8'd3, 8'd3, 8'h00, 8'h40, 32'h01010101);
    run_job(60, 0, 1'b0, 9);
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || rd_en !== 1'b0 || wr_en !== 1'b0) begin failures++;
      $display("FAIL midrst_ctrl got=busy%b done%b rd%b wr%b exp=0000", busy, done, rd_en, wr_en); end
    checks++; if (rd_addr !== 8'h00 || wr_addr !== 8'h00 || wr_data !== 8'h00 || mac_a !== 32'h0 || mac_k !== 32'h0) begin
      failures++; $display("FAIL midrst_data got=%h/%h/%h/%h/%h exp=zeros", rd_addr, wr_addr, wr_data, mac_a, mac_k); end
    checks++; if (wa_q.size() !== 1 || ndone !== 0) begin failures++;
      $display("FAIL midrst_partial got=wr%0d done%0d exp=wr1 done0", wa_q.size(), ndone); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    late_done = 0;
    repeat (6) begin
      @(negedge clk);
      if (done || busy) late_done++;
    end
    checks++; if (late_done !== 0) begin failures++; $display("FAIL midrst_idle_after got=%0d exp=0", late_done); end
    set_cfg(8'd3, 8'd3, 8'h00, 8'h40, 32'h01010101);
    run_job(60, 0, 1'b0, 0);
    checks++; if (done_cyc !== 25 || ndone !== 1) begin failures++;
      $display("FAIL midrst_rerun_done got=%0d n=%0d exp=25 n=1", done_cyc, ndone); end
    checks++; if (rd_q.size() !== 16) begin failures++; $display("FAIL midrst_rerun_reads got=%0d exp=16", rd_q.size()); end
    else begin
      checks++; if (rd_q[0] !== 8'h00 || rd_q[1] !== 8'h01 || rd_q[2] !== 8'h03 || rd_q[3] !== 8'h04) begin failures++;
        $display("FAIL midrst_rerun_first_window got=%h %h %h %h exp=00 01 03 04", rd_q[0], rd_q[1], rd_q[2], rd_q[3]); end
    end
    checks++; if (wa_q.size() !== 4) begin failures++; $display("FAIL midrst_rerun_writes got=%0d exp=4", wa_q.size()); end
    else begin
      checks++; if (wa_q[0] !== 8'h40 || wa_q[3] !== 8'h43 || wd_q[0] !== 8'h04 || wd_q[3] !== 8'h04) begin failures++;
        $display("FAIL midrst_rerun_write_vals got=%h:%h..%h:%h exp=40:04..43:04", wa_q[0], wd_q[0], wa_q[3], wd_q[3]); end
    end
  endtask

  task automatic test_back_to_back();
    clear_mem();
    for (int i = 0; i < 9; i++) mem[i] = 8'h01;
    set_cfg(8'd3, 8'd3, 8'h00, 8'h40, 32'h01010101);
    run_job(60, 10, 1'b1, 0);
    checks++; if (ndone !== 1 || done_cyc !== 25) begin failures++;
      $display("FAIL ignore_start_done got=%0d n=%0d exp=25 n=1", done_cyc, ndone); end
    checks++; if (wa_q.size() !== 4) begin failures++; $display("FAIL ignore_start_writes got=%0d exp=4", wa_q.size()); end
    checks++; if (nbusy !== 24 || busy_last !== 24) begin failures++;
      $display("FAIL ignore_start_busy got=n%0d last%0d exp=n24 last24", nbusy, busy_last); end
    checks++; if (rd_q.size() !== 16) begin failures++; $display("FAIL ignore_start_reads got=%0d exp=16", rd_q.size()); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_mem();
    test_reset();
    test_ones_3x3();
    test_3x2_ramp();
    test_degenerate();
    test_wrap();
    test_reset_midjob();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/conv2x2_sched.md
# conv2x2_sched

Sequencer for the 2x2 multiply-accumulate datapath in the near-memory CNN accelerator. On each start command it walks a stride-1 valid 2x2 convolution over a feature map held in local SRAM. For every window it fetches the four pixels through a single read port, presents the window and the latched kernel to the external MAC unit, and writes the truncated sum back to SRAM. The block sits between the bank controller's SRAM ports and the MAC datapath.

## Interface
- WIDTH, 8, pixel, kernel and result width in bits
- ADDR_W, 8, SRAM address width; also the width of the dimension inputs

- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle command pulse; sampled only in IDLE
- img_w, img_h  in  ADDR_W each  feature-map width and height in pixels
- in_base, out_base  in  ADDR_W each  base address of the input map and of the output map
- kernel  in  4*WIDTH  kernel; element k at [k*WIDTH +: WIDTH]; latched on an accepted start
- busy  out  1  high from the first fetch cycle through the last write cycle
- done  out  1  one-cycle pulse when the job completes
- rd_en  out  1  SRAM read strobe
- rd_addr  out  ADDR_W  SRAM read address
- rd_data  in  WIDTH  read data; valid exactly one cycle after the rd_en cycle
- mac_a, mac_k  out  4*WIDTH each  window and kernel presented to the MAC
- mac_out  in  WIDTH  combinational MAC result
- wr_en  out  1  SRAM write strobe
- wr_addr  out  ADDR_W  SRAM write address
- wr_data  out  WIDTH  SRAM write data

## Operation
- FSM states: IDLE, F0, F1, F2, F3, WAIT, WRITE, DONE.
- IDLE: when start=1, latch img_w, img_h, in_base, out_base and kernel, set r=c=0, then go to F0.
- IDLE degenerate case: if img_w<2 or img_h<2, go straight to DONE; no reads and no writes occur.
- Window (r,c) element order:
  - a0=(r,c), a1=(r,c+1), a2=(r+1,c), a3=(r+1,c+1)
  - Fk issues rd_en=1 with rd_addr = in_base + row_base + offset_k
  - offset_k values: 0, 1, img_w, img_w+1
  - row_base = r*img_w, kept as a running register (add img_w per row; no multiplier)
- Window capture: data for the read issued in Fk lands in window slot k on the next edge. WAIT captures slot 3.
- WRITE:
  - wr_en=1, wr_addr=out_addr, wr_data=mac_out
  - mac_a = window register; mac_k = latched kernel, driven at all times
- Advance after WRITE: out_addr+1 and c+1.
  - If c reaches img_w-1: c=0 and r+1.
  - If r reaches img_h-1: go to DONE; otherwise go to F0.
- DONE: done=1 for one cycle, then go to IDLE.
- Arithmetic: all addresses wrap modulo 2^ADDR_W. The result is mac_out as delivered (WIDTH bits, mod 2^WIDTH); no saturation.
- start outside IDLE is ignored, including in DONE.
- A change on the config inputs during a job has no effect.

## Timing
- Reset values: state=IDLE; busy, done, rd_en and wr_en are 0; rd_addr, wr_addr, wr_data, mac_a and mac_k are all zero.
- Cycle numbering: start is accepted at edge 0, and the first F0 is cycle 1.
- Each window takes exactly 6 cycles (F0–F3, WAIT, WRITE).
- For N = (img_w-1)*(img_h-1) windows:
  - busy is high on cycles 1..6N
  - done pulses on cycle 6N+1
  - degenerate case: done pulses on cycle 1 and busy never rises
- rd_en and wr_en are never high in the same cycle. At most one read is outstanding.
- Reset mid-job: on rst assertion, return to IDLE immediately (asynchronously) with reset output values. A partial job is abandoned; no done pulse.

## Structure
- Package cnn_pkg holds:
  - the FSM state enum
  - window slot index constants (SLOT_A0..SLOT_A3)
- Sub-module conv_addr_gen holds r, c, row_base and out_addr. It takes step and clear inputs and outputs rd_addr per slot, wr_addr and a last-window flag.
- The FSM and the window/kernel registers stay in conv2x2_sched.

## Test plan
- 3x3 map of all 1s, kernel all 1s, out_base=0x40:
  - 4 writes of 4 to 0x40..0x43
  - done pulses at cycle 25; busy is high on cycles 1..24
- 3x2 map holding 1..6 row-major, kernel {1,2,3,4}, in_base=0:
  - reads 0,1,3,4 then 1,2,4,5
  - writes 1+4+12+20=37, then 2+6+15+24=47
- img_w=1, img_h=5: done pulses on cycle 1; no rd_en and no wr_en.
- Wrap-around: in_base=0xFE with a 2x2 map:
  - reads 0xFE, 0xFF, 0x00, 0x01
  - all pixels 0xFF with kernel all 0xFF: wr_data = mac_out truncated to 8 bits
- rst asserted during F2 of window 2:
  - all outputs drop to 0 immediately; no done pulse
  - a new start then runs a full job correctly from window (0,0)
- start pulsed while busy and again in DONE: both ignored; a single done pulse; write count unchanged.
